// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   IF_WORD / IF_INST_SIZE : default PC and instruction widths of the LEGv8 core
//   FETCH_DEPTH            : default fetch FIFO depth
//   PC_INC                 : byte stride between sequential instructions
//   fetch_entry_t          : {pc, inst} pair as stored in the fetch FIFO
package if_pkg;

   localparam int unsigned IF_WORD      = 64;
   localparam int unsigned IF_INST_SIZE = 32;
   localparam int unsigned FETCH_DEPTH  = 2;
   localparam int unsigned PC_INC       = 4;

   typedef struct packed {
      logic [IF_WORD-1:0]      pc;
      logic [IF_INST_SIZE-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, reusable for fetch and decode buffering.
//   clk       : clock, all state on rising edge
//   reset     : synchronous active-high reset (empties the FIFO)
//   flush     : empties the FIFO; has priority over push and pop
//   push      : write push_data at the tail (caller guarantees not full unless popping)
//   push_data : entry to write
//   pop       : drop the head entry (caller guarantees not empty)
//   head_data : current head entry, held in registers
//   count     : occupancy 0..DEPTH
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 96
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
   end

   // Storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push && !flush && !reset) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, sequences inst_mem and buffers {pc, inst}
// pairs for decode behind a valid/ready handshake.
//   clk, reset            : clock and synchronous active-high reset
//   mem_read, mem_pc      : read strobe and address to inst_mem
//   mem_inst              : combinational read data from inst_mem
//   br_valid, br_target   : redirect request from execute (flushes the FIFO)
//   if_valid, if_ready    : head handshake to decode
//   if_pc, if_inst        : head entry
//   if_count              : FIFO occupancy
module inst_fetch_ctrl
   import if_pkg::*;
#(
   parameter int unsigned    WORD      = IF_WORD,
   parameter int unsigned    INST_SIZE = IF_INST_SIZE,
   parameter logic [WORD-1:0] RESET_PC = '0,
   parameter int unsigned    DEPTH     = FETCH_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     mem_read,
   output logic [WORD-1:0]          mem_pc,
   input  logic [INST_SIZE-1:0]     mem_inst,
   input  logic                     br_valid,
   input  logic [WORD-1:0]          br_target,
   output logic                     if_valid,
   input  logic                     if_ready,
   output logic [WORD-1:0]          if_pc,
   output logic [INST_SIZE-1:0]     if_inst,
   output logic [$clog2(DEPTH):0]   if_count
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WORD-1:0]           pc_q;
   logic [WORD-1:0]           pc_d;
   logic [CW-1:0]             count;
   logic [WORD+INST_SIZE-1:0] head;
   logic                      head_valid;
   logic                      pop_req;
   logic                      pop;
   logic                      push_ok;
   logic                      fetch;

   assign head_valid = (count != '0);
   assign pop_req    = head_valid & if_ready;
   // A full FIFO still accepts a fetch when the head leaves in the same cycle.
   assign push_ok    = (count < CW'(DEPTH)) | pop_req;
   assign fetch      = ~reset & ~br_valid & push_ok;
   // A redirect swallows the handshake: the head is flushed, not consumed.
   assign pop        = pop_req & ~br_valid & ~reset;

   always_comb begin
      pc_d = pc_q;
      if (br_valid) begin
         pc_d = {br_target[WORD-1:2], 2'b00};
      end else if (fetch) begin
         pc_d = pc_q + WORD'(PC_INC);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WORD + INST_SIZE)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (br_valid),
      .push      (fetch),
      .push_data ({pc_q, mem_inst}),
      .pop       (pop),
      .head_data (head),
      .count     (count)
   );

   // Outputs are forced quiet while reset is held, independent of stale state.
   assign mem_read = fetch;
   assign mem_pc   = reset ? RESET_PC : pc_q;
   assign if_valid = ~reset & head_valid;
   assign if_pc    = if_valid ? head[WORD+INST_SIZE-1:INST_SIZE] : '0;
   assign if_inst  = if_valid ? head[INST_SIZE-1:0] : '0;
   assign if_count = reset ? '0 : count;

`ifndef SYNTHESIS
   a_count_max : assert property (@(posedge clk) count <= CW'(DEPTH));
   a_pc_align  : assert property (@(posedge clk) if_pc[1:0] == 2'b00);
   a_stall_hold : assert property (@(posedge clk) disable iff (reset)
      (if_valid && !if_ready && !br_valid) |=> ($stable(if_pc) && $stable(if_inst)));
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios followed by random traffic, all
// checked every cycle against a queue-based model of the fetch stage.
module tb_inst_fetch_ctrl;

   localparam int unsigned    DEPTH    = 2;
   localparam logic [63:0]    RESET_PC = 64'd0;

   logic        tb_clk;
   logic        reset;
   logic        mem_read;
   logic [63:0] mem_pc;
   logic [31:0] mem_inst;
   logic        br_valid;
   logic [63:0] br_target;
   logic        if_valid;
   logic        if_ready;
   logic [63:0] if_pc;
   logic [31:0] if_inst;
   logic [1:0]  if_count;

   int tests = 0;
   int fails = 0;

   // Model: queue of buffered PCs plus next fetch PC.
   logic [63:0] mq [$];
   logic [63:0] mpc = RESET_PC;

   // Test image: inst == pc/4.
   assign mem_inst = mem_pc[33:2];

   inst_fetch_ctrl #(
      .WORD      (64),
      .INST_SIZE (32),
      .RESET_PC  (RESET_PC),
      .DEPTH     (DEPTH)
   ) dut (
      .clk       (tb_clk),
      .reset     (reset),
      .mem_read  (mem_read),
      .mem_pc    (mem_pc),
      .mem_inst  (mem_inst),
      .br_valid  (br_valid),
      .br_target (br_target),
      .if_valid  (if_valid),
      .if_ready  (if_ready),
      .if_pc     (if_pc),
      .if_inst   (if_inst),
      .if_count  (if_count)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: compare against the model mid-cycle, then advance the model at the edge.
   task automatic cycle();
      int          n;
      logic        e_valid;
      logic        e_pop;
      logic        e_read;
      logic [63:0] e_pc;
      @(negedge tb_clk);
      n       = mq.size();
      e_valid = !reset && (n != 0);
      e_pc    = e_valid ? mq[0] : 64'd0;
      e_pop   = e_valid && if_ready;
      e_read  = !reset && !br_valid && ((n < DEPTH) || e_pop);
      check("if_valid", {63'd0, if_valid}, {63'd0, e_valid});
      check("if_pc", if_pc, e_pc);
      check("if_inst", {32'd0, if_inst}, {32'd0, e_pc[33:2]});
      check("if_count", {62'd0, if_count}, reset ? 64'd0 : 64'(n));
      check("mem_read", {63'd0, mem_read}, {63'd0, e_read});
      check("mem_pc", mem_pc, reset ? RESET_PC : mpc);
      @(posedge tb_clk);
      if (reset) begin
         mq.delete();
         mpc = RESET_PC;
      end else if (br_valid) begin
         mq.delete();
         mpc = {br_target[63:2], 2'b00};
      end else begin
         if (e_pop) void'(mq.pop_front());
         if (e_read) begin
            mq.push_back(mpc);
            mpc = mpc + 64'd4;
         end
      end
      #1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   logic [63:0] head_pc;

   initial begin
      reset     = 1'b1;
      br_valid  = 1'b0;
      br_target = 64'd0;
      if_ready  = 1'b0;
      cycles(2);

      // 1: streaming from reset, ready held high.
      reset    = 1'b0;
      if_ready = 1'b1;
      cycle();
      check("t1_first_valid", {63'd0, if_valid}, 64'd1);
      check("t1_first_pc", if_pc, 64'd0);
      cycles(64);

      // 2: backpressure from reset, then drain.
      reset    = 1'b1;
      if_ready = 1'b0;
      cycle();
      reset = 1'b0;
      cycles(2);
      check("t2_count_full", {62'd0, if_count}, 64'd2);
      check("t2_no_read", {63'd0, mem_read}, 64'd0);
      check("t2_pc_hold", mem_pc, 64'd8);
      if_ready = 1'b1;
      #1;
      check("t2_read_on_pop", {63'd0, mem_read}, 64'd1);
      head_pc = if_pc;
      cycle();
      // 5a: full + pop + fetch keeps count, advances head and pc.
      check("t5_count_kept", {62'd0, if_count}, 64'd2);
      check("t5_head_adv", if_pc, head_pc + 64'd4);
      check("t5_pc_adv", mem_pc, 64'd12);
      cycles(6);

      // 3: redirect mid-stream at pc 20.
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      cycles(5);
      br_valid  = 1'b1;
      br_target = 64'h100;
      #1;
      check("t3_no_read", {63'd0, mem_read}, 64'd0);
      cycle();
      br_valid = 1'b0;
      check("t3_flushed", {63'd0, if_valid}, 64'd0);
      check("t3_count0", {62'd0, if_count}, 64'd0);
      check("t3_target", mem_pc, 64'h100);
      cycle();
      check("t3_if_pc", if_pc, 64'h100);
      check("t3_if_inst", {32'd0, if_inst}, 64'h40);

      // 4: misaligned target masked.
      br_valid  = 1'b1;
      br_target = 64'h103;
      cycle();
      br_valid = 1'b0;
      cycle();
      check("t4_masked", if_pc, 64'h100);
      cycles(4);

      // 5b: redirect together with ready: flush wins.
      if_ready = 1'b0;
      cycles(3);
      check("t5_full", {62'd0, if_count}, 64'd2);
      if_ready  = 1'b1;
      br_valid  = 1'b1;
      br_target = 64'h200;
      cycle();
      br_valid = 1'b0;
      check("t5_flush_cnt", {62'd0, if_count}, 64'd0);
      check("t5_flush_pc", mem_pc, 64'h200);
      cycles(3);

      // 6: reset mid-stream with a full FIFO at pc 0x40.
      if_ready  = 1'b0;
      br_valid  = 1'b1;
      br_target = 64'h38;
      cycle();
      br_valid = 1'b0;
      cycles(2);
      check("t6_full", {62'd0, if_count}, 64'd2);
      check("t6_pc40", mem_pc, 64'h40);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("t6_valid0", {63'd0, if_valid}, 64'd0);
      check("t6_count0", {62'd0, if_count}, 64'd0);
      check("t6_reset_pc", mem_pc, RESET_PC);
      if_ready = 1'b1;
      cycle();
      check("t6_restart", if_pc, 64'd0);
      cycles(3);

      // PC wraps modulo 2^64.
      br_valid  = 1'b1;
      br_target = 64'hFFFF_FFFF_FFFF_FFFB;
      cycle();
      br_valid = 1'b0;
      cycles(2);
      check("wrap_pc", mem_pc, 64'd0);
      cycles(4);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(49) == 0);
         br_valid  = ($urandom_range(11) == 0);
         br_target = {$urandom, $urandom};
         if_ready  = ($urandom_range(3) != 0);
         cycle();
      end
      reset    = 1'b0;
      br_valid = 1'b0;
      if_ready = 1'b1;
      cycles(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
